// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and counter sizing for the push-button debouncer
//
// Purpose : default channel count and stability threshold, plus the width
//           helper used to size each channel's stability counter.

package debounce_pkg;

    localparam int N_BTN_DEF         = 9;
    localparam int STABLE_CYCLES_DEF = 4;

    // Counter must represent 0..STABLE_CYCLES; never narrower than one bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - single-channel debouncer: optional synchronizer, stability counter, level register
//
// Purpose : accepts a new button level only after it has been seen on
//           STABLE_CYCLES consecutive clk_d edges; any matching sample in
//           between restarts the count.
// Config  : BTN_DEBOUNCE_SYNC_EN adds a two-flop synchronizer ahead of the
//           filter (two extra edges of latency). Without it the raw input is
//           used directly and must already be synchronous to clk_d.
// Ports   : clk_d     - divided game clock, rising edge
//           rst       - synchronous active-high reset
//           pb_raw    - raw button level, 1 = pressed
//           level     - registered debounced level
//           level_nxt - value level will take on the next edge

module debounce_cell
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk_d,
    input  logic rst,
    input  logic pb_raw,
    output logic level,
    output logic level_nxt
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

`ifdef BTN_DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_d) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pb_raw};
        end
    end

    assign s = sync_q[1];
`else
    assign s = pb_raw;
`endif

    // The counter only runs while the sample disagrees with the accepted
    // level; on the final disagreeing edge the level flips and the count
    // clears, so cnt never passes CNT_LAST.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '0;
        if (s != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = s;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            level <= level_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - array of independent button debouncers with any-pressed and change flags
//
// Purpose : N_BTN independent debounce cells plus two registered summary
//           flags derived from the cells' next-state levels, so both flags
//           line up with the pb_d update they describe.
// Config  : BTN_DEBOUNCE_SYNC_EN (see debounce_cell) enables per-channel
//           input synchronizers.
// Ports   : clk_d  - divided game clock, rising edge
//           rst    - synchronous active-high reset
//           pb_raw - raw bouncing button levels, 1 = pressed
//           pb_d   - debounced levels, registered
//           any_d  - registered OR of the debounced levels
//           chg    - one-cycle pulse alongside each pb_d update

module btn_debounce
    import debounce_pkg::*;
#(
    parameter int N_BTN         = N_BTN_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk_d,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb_raw,
    output logic [N_BTN-1:0] pb_d,
    output logic             any_d,
    output logic             chg
);

    logic [N_BTN-1:0] pb_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_cell
        debounce_cell #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_cell (
            .clk_d    (clk_d),
            .rst      (rst),
            .pb_raw   (pb_raw[i]),
            .level    (pb_d[i]),
            .level_nxt(pb_nxt[i])
        );
    end

    // Several channels flipping on one edge still yield a single chg cycle,
    // because the detector looks at the whole vector at once.
    always_ff @(posedge clk_d) begin
        if (rst) begin
            any_d <= 1'b0;
            chg   <= 1'b0;
        end else begin
            any_d <= |pb_nxt;
            chg   <= |(pb_nxt ^ pb_d);
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - self-checking bench for btn_debounce against a timestamp-based reference model

module tb_btn_debounce;
    import debounce_pkg::*;

    localparam int NB = N_BTN_DEF;
    localparam int SC = STABLE_CYCLES_DEF;
`ifdef BTN_DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LAT = SC + SYNC_LAT;

    logic          clk_d = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] pb_raw = '0;
    logic [NB-1:0] pb_d;
    logic          any_d;
    logic          chg;

    always #5 clk_d = ~clk_d;

    btn_debounce dut (
        .clk_d (clk_d),
        .rst   (rst),
        .pb_raw(pb_raw),
        .pb_d  (pb_d),
        .any_d (any_d),
        .chg   (chg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Reference model: a level flips once the sample has disagreed with it
    // on every edge since the last agreeing edge (or reset / previous flip),
    // and that span has reached SC edges.
    logic [NB-1:0] m_lvl = '0;
    int            m_last_ok[NB];
    logic [NB-1:0] raw_hist[$];
    logic          m_any = 1'b0;
    logic          m_chg = 1'b0;

    int rise_e;
    int nchg;
    int e0;
    int rst_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_edge(input logic r, input logic [NB-1:0] v);
        logic [NB-1:0] s;
        logic [NB-1:0] old;
        old = m_lvl;
        if (r) begin
            m_lvl = '0;
            for (int i = 0; i < NB; i++) m_last_ok[i] = edge_n;
            raw_hist.delete();
            for (int k = 0; k < SYNC_LAT; k++) raw_hist.push_back('0);
            m_any = 1'b0;
            m_chg = 1'b0;
        end else begin
            raw_hist.push_back(v);
            s = raw_hist.pop_front();
            for (int i = 0; i < NB; i++) begin
                if (s[i] == m_lvl[i]) begin
                    m_last_ok[i] = edge_n;
                end else if (edge_n - m_last_ok[i] >= SC) begin
                    m_lvl[i]     = s[i];
                    m_last_ok[i] = edge_n;
                end
            end
            m_any = |m_lvl;
            m_chg = (m_lvl != old);
        end
    endtask

    task automatic step(input logic r, input logic [NB-1:0] v);
        rst    = r;
        pb_raw = v;
        @(posedge clk_d);
        edge_n++;
        model_edge(r, v);
        @(negedge clk_d);
        chk("pb_d", 32'(pb_d), 32'(m_lvl));
        chk("any_d", 32'(any_d), 32'(m_any));
        chk("chg", 32'(chg), 32'(m_chg));
    endtask

    // Hold v for n edges; note the first edge where pb_d[idx] departs from
    // its starting value and how many cycles chg was high.
    task automatic run(input int n, input logic [NB-1:0] v, input int idx);
        logic start;
        start  = pb_d[idx];
        rise_e = -1;
        nchg   = 0;
        for (int k = 0; k < n; k++) begin
            step(1'b0, v);
            if (rise_e < 0 && pb_d[idx] != start) rise_e = edge_n;
            nchg += int'(chg);
        end
    endtask

    initial begin
        logic [NB-1:0] rv;
        for (int i = 0; i < NB; i++) m_last_ok[i] = 0;
        for (int k = 0; k < SYNC_LAT; k++) raw_hist.push_back('0);

        // Reset with buttons apparently pressed: everything must stay low.
        step(1'b1, '1);
        step(1'b1, '1);
        step(1'b1, '0);
        chk("rst_pb_d", 32'(pb_d), 32'h0);
        chk("rst_chg", 32'(chg), 32'h0);
        chk("rst_any", 32'(any_d), 32'h0);
        repeat (2) step(1'b0, '0);

        // Clean press on channel 0.
        e0 = edge_n;
        run(LAT + 4, NB'(9'h001), 0);
        chk("press_lat", 32'(rise_e - e0), 32'(LAT));
        chk("press_chg_cnt", 32'(nchg), 32'd1);
        chk("press_any", 32'(any_d), 32'd1);

        // Release of channel 0.
        e0 = edge_n;
        run(LAT + 4, '0, 0);
        chk("release_lat", 32'(rise_e - e0), 32'(LAT));
        chk("release_chg_cnt", 32'(nchg), 32'd1);
        chk("release_any", 32'(any_d), 32'd0);

        // Bounce on channel 3: 1,0,1,0 then 1 held.
        step(1'b0, NB'(9'h008));
        step(1'b0, NB'(9'h000));
        step(1'b0, NB'(9'h008));
        step(1'b0, NB'(9'h000));
        chk("bounce_early", 32'(pb_d), 32'h0);
        e0 = edge_n;
        run(LAT + 4, NB'(9'h008), 3);
        chk("bounce_lat", 32'(rise_e - e0), 32'(LAT));
        chk("bounce_chg_cnt", 32'(nchg), 32'd1);
        run(LAT + 4, '0, 3);

        // Glitch on channel 5, shorter than the threshold.
        step(1'b1, '0);
        step(1'b0, '0);
        run(SC - 1, NB'(9'h020), 5);
        chk("glitch_hi_chg", 32'(nchg), 32'd0);
        run(LAT + 4, '0, 5);
        chk("glitch_rise", 32'(rise_e), 32'hFFFF_FFFF);
        chk("glitch_chg", 32'(nchg), 32'd0);
        chk("glitch_pb_d", 32'(pb_d), 32'h0);

        // All channels pressed together.
        e0 = edge_n;
        run(LAT + 4, '1, 0);
        chk("simul_lat", 32'(rise_e - e0), 32'(LAT));
        chk("simul_chg_cnt", 32'(nchg), 32'd1);
        chk("simul_pb_d", 32'(pb_d), 32'(NB'(9'h1FF)));

        // Reset on the third mismatch edge of channel 2.
        step(1'b1, '0);
        step(1'b0, '0);
        for (int k = 0; k < SYNC_LAT + 2; k++) step(1'b0, NB'(9'h004));
        step(1'b1, NB'(9'h004));
        rst_e = edge_n;
        run(LAT + 4, NB'(9'h004), 2);
        chk("midrst_lat", 32'(rise_e - rst_e), 32'(LAT));
        chk("midrst_pb_d", 32'(pb_d), 32'h004);

        // Randomized bursts with occasional reset.
        step(1'b1, '0);
        rv = '0;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 4) == 0) rv[i] = ~rv[i];
            step(($urandom_range(0, 149) == 0), rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
